// File: rtl/c5g_housekeeping_pwr_seq_master.sv
// ---------------------------------------------------------------------------
// c5g_housekeeping_pwr_seq_master
// Avalon-MM master that switches the camera pwdn_n PIO on a hardware request.
// It writes the target level, waits a settle delay, reads the register back
// and checks bit 0. The result is reported with a one-cycle done pulse, a
// sticky error flag and the last verified level on powered.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   pwr_up_req          1-cycle request to drive pwdn_n = 1
//   pwr_dn_req          1-cycle request to drive pwdn_n = 0 (wins on a tie)
//   busy                high from request acceptance until the done cycle
//   done                1-cycle pulse at the end of every sequence
//   error               sticky failure flag, cleared by the next request
//   powered             last pwdn_n value verified by read-back
//   avm_*               Avalon-MM master port (address, write, read,
//                       writedata, readdata, readdatavalid, waitrequest)
// ---------------------------------------------------------------------------
module c5g_housekeeping_pwr_seq_master #(
  parameter int unsigned       ADDR_W       = 4,
  parameter logic [ADDR_W-1:0] PWDN_ADDR    = '0,
  parameter int unsigned       DELAY_CYCLES = 50000,
  parameter int unsigned       TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwr_up_req,
  input  logic              pwr_dn_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              powered,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  // Counters hold DELAY_CYCLES-1 / TIMEOUT-1 at most.
  localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_SETTLE,
    S_RD,
    S_RDWAIT,
    S_FIN
  } state_t;

  state_t           state;
  logic             target;
  logic [DLY_W-1:0] dly_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Only bit 0 of the PIO data register carries pwdn_n.
  logic rd_match_c;
  logic unused_readdata_hi;
  assign rd_match_c         = (avm_readdata[0] == target);
  assign unused_readdata_hi = ^avm_readdata[31:1];

  // Sequencer: single registered FSM, every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      target        <= 1'b0;
      dly_cnt       <= '0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      powered       <= 1'b0;
      avm_address   <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_writedata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pwr_dn_req || pwr_up_req) begin
            target        <= !pwr_dn_req;
            error         <= 1'b0;
            busy          <= 1'b1;
            avm_write     <= 1'b1;
            avm_address   <= PWDN_ADDR;
            avm_writedata <= {31'b0, !pwr_dn_req};
            state         <= S_WR;
          end
        end

        // Write held stable until the slave stops stalling.
        S_WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            dly_cnt   <= DLY_W'(DELAY_CYCLES - 1);
            state     <= S_SETTLE;
          end
        end

        // Exactly DELAY_CYCLES idle bus cycles before the read is issued.
        S_SETTLE: begin
          if (dly_cnt == '0) begin
            avm_read    <= 1'b1;
            avm_address <= PWDN_ADDR;
            state       <= S_RD;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end

        // Read accept; a zero-latency slave may return data in this cycle.
        S_RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            tmo_cnt  <= '0;
            if (avm_readdatavalid) begin
              if (rd_match_c) begin
                powered <= target;
              end else begin
                error <= 1'b1;
              end
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_RDWAIT;
            end
          end
        end

        // Data valid in the TIMEOUT-th wait cycle is still accepted.
        S_RDWAIT: begin
          if (avm_readdatavalid) begin
            if (rd_match_c) begin
              powered <= target;
            end else begin
              error <= 1'b1;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // done is high during this cycle; requests are taken from the next.
        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
